// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcode map,
// datapath select encodings and the bundled control-word struct. The ALU and
// extender wrappers import the same encodings.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_HALT     = 4'd11,
    ST_ERRSTOP  = 4'd12
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_PASSB = 3'd4
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'd0,
    SRCB_TWO  = 2'd1,
    SRCB_IMM  = 2'd2
  } alusrcb_e;

  typedef enum logic [1:0] {
    IMM_SEXT     = 2'd0,
    IMM_ZEXT     = 2'd1,
    IMM_SEXT_SH1 = 2'd2
  } immsel_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pcsrc_e;

  typedef struct packed {
    logic     mem_req;
    logic     mem_we;
    logic     iord;
    logic     pcwrite;
    pcsrc_e   pcsrc;
    logic     irwrite;
    logic     regwrite;
    logic     memtoreg;
    logic     alusrca;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    immsel_e  immsel;
    logic     halted;
    logic     err;
  } ctrl_t;

  // ALU operation for a register-register opcode.
  function automatic aluop_e rtype_aluop(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // States that hold a memory request open until MEM_READY.
  function automatic logic is_req_state(input state_e s);
    case (s)
      ST_FETCH, ST_MEM_RD, ST_MEM_WR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the control FSM (master) and the datapath/memory
// side (slave). Signal names follow the datapath schematic.
interface mc_control_fsm_if #(parameter int OPW = 4);
  import mc_ctrl_pkg::*;

  logic [OPW-1:0]     OPCODE;
  logic               ZERO;
  logic               MEM_READY;
  logic               MEM_REQ;
  logic               MEM_WE;
  logic               IORD;
  logic               PCWRITE;
  logic [1:0]         PCSRC;
  logic               IRWRITE;
  logic               REGWRITE;
  logic               MEMTOREG;
  logic               ALUSRCA;
  logic [1:0]         ALUSRCB;
  logic [2:0]         ALUOP;
  logic [1:0]         IMMSEL;
  logic               HALTED;
  logic               ERR;
  logic [STATE_W-1:0] STATE;

  modport master (
    input  OPCODE, ZERO, MEM_READY,
    output MEM_REQ, MEM_WE, IORD, PCWRITE, PCSRC, IRWRITE, REGWRITE, MEMTOREG,
           ALUSRCA, ALUSRCB, ALUOP, IMMSEL, HALTED, ERR, STATE
  );

  modport slave (
    output OPCODE, ZERO, MEM_READY,
    input  MEM_REQ, MEM_WE, IORD, PCWRITE, PCSRC, IRWRITE, REGWRITE, MEMTOREG,
           ALUSRCA, ALUSRCB, ALUOP, IMMSEL, HALTED, ERR, STATE
  );

endinterface

// File: rtl/mc_mem_waiter.sv
// Memory wait tracker. The request itself is held by the FSM staying in its
// request state; this block reports completion and counts non-ready cycles,
// raising a timeout on the MEM_TIMEOUT-th consecutive wait (0 = never).
module mc_mem_waiter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic ready_i,
  output logic done_o,
  output logic timeout_o
);

  localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [3:0] TIMEOUT_LAST = 4'((MEM_TIMEOUT == 0) ? 1 : (MEM_TIMEOUT - 1));

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       timeout_s;

  // Wait counter: runs only while a request is pending and unanswered; any
  // completion or non-request cycle clears it, so every request starts at 0.
  always_comb begin
    cnt_d     = 4'd0;
    timeout_s = 1'b0;
    if (req_i && !ready_i) begin
      if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
      if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
        timeout_s = 1'b1;
      end else begin
        timeout_s = 1'b0;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Counter register; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o    = req_i & ready_i;
  assign timeout_o = timeout_s;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit datapath. Drives PC/IR/regfile/ALU/
// memory/extender controls per state and handshakes with memory via
// MEM_REQ/MEM_READY. Optional macro MC_CTRL_ILLEGAL_TRAP_EN: opcodes B-E trap
// to ERRSTOP instead of executing as NOP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  mc_control_fsm_if.master  bus
);

  state_e     state_q;
  state_e     state_d;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;
  logic [3:0] op_s;
  logic       req_s;
  logic       done_s;
  logic       timeout_s;

  assign op_s  = 4'(bus.OPCODE);
  assign req_s = is_req_state(state_q);

  mc_mem_waiter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_waiter (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .req_i     (req_s),
    .ready_i   (bus.MEM_READY),
    .done_o    (done_s),
    .timeout_o (timeout_s)
  );

  // State register: reset lands in FETCH from anywhere, mid-wait included.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; request states advance only on completion or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (done_s)         state_d = ST_DECODE;
        else if (timeout_s) state_d = ST_ERRSTOP;
        else                state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXEC_R;
          OP_ADDI, OP_ORI:               state_d = ST_EXEC_I;
          OP_LW, OP_SW:                  state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_d = ST_BRANCH;
          OP_J:                          state_d = ST_JUMP;
          OP_HALT:                       state_d = ST_HALT;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = ST_ERRSTOP;
`else
            state_d = ST_FETCH;
`endif
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_MEM_ADDR: begin
        if (op_s == OP_SW) state_d = ST_MEM_WR;
        else               state_d = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        if (done_s)         state_d = ST_WB_MEM;
        else if (timeout_s) state_d = ST_ERRSTOP;
        else                state_d = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (done_s)         state_d = ST_FETCH;
        else if (timeout_s) state_d = ST_ERRSTOP;
        else                state_d = ST_MEM_WR;
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      ST_ERRSTOP: state_d = ST_ERRSTOP;
      default:    state_d = ST_ERRSTOP;
    endcase
  end

  // Control word per state; write enables are single-cycle by construction.
  always_comb begin
    ctrl_s = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.alusrcb = SRCB_TWO;
        ctrl_s.aluop   = ALU_ADD;
        ctrl_s.irwrite = done_s;
        ctrl_s.pcwrite = done_s;
        ctrl_s.pcsrc   = PC_ALU;
      end
      ST_DECODE: begin
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsel  = IMM_SEXT_SH1;
        ctrl_s.aluop   = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_REGB;
        ctrl_s.aluop   = rtype_aluop(op_s);
      end
      ST_EXEC_I: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        if (op_s == OP_ORI) begin
          ctrl_s.immsel = IMM_ZEXT;
          ctrl_s.aluop  = ALU_OR;
        end else begin
          ctrl_s.immsel = IMM_SEXT;
          ctrl_s.aluop  = ALU_ADD;
        end
      end
      ST_MEM_ADDR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsel  = IMM_SEXT;
        ctrl_s.aluop   = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
        ctrl_s.mem_we  = 1'b1;
      end
      ST_WB_ALU: ctrl_s.regwrite = 1'b1;
      ST_WB_MEM: begin
        ctrl_s.regwrite = 1'b1;
        ctrl_s.memtoreg = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = SRCB_REGB;
        ctrl_s.aluop   = ALU_SUB;
        ctrl_s.pcsrc   = PC_ALUOUT;
        ctrl_s.pcwrite = (op_s == OP_BNE) ? ~bus.ZERO : bus.ZERO;
      end
      ST_JUMP: begin
        ctrl_s.pcwrite = 1'b1;
        ctrl_s.pcsrc   = PC_JUMP;
      end
      ST_HALT: ctrl_s.halted = 1'b1;
      ST_ERRSTOP: begin
        ctrl_s.halted = 1'b1;
        ctrl_s.err    = 1'b1;
      end
      default: begin
        ctrl_s.halted = 1'b1;
        ctrl_s.err    = 1'b1;
      end
    endcase
  end

  // While reset is held every output is forced low, FETCH's request included.
  assign ctrl_out_s = RST_N ? ctrl_s : '0;

  assign bus.MEM_REQ  = ctrl_out_s.mem_req;
  assign bus.MEM_WE   = ctrl_out_s.mem_we;
  assign bus.IORD     = ctrl_out_s.iord;
  assign bus.PCWRITE  = ctrl_out_s.pcwrite;
  assign bus.PCSRC    = ctrl_out_s.pcsrc;
  assign bus.IRWRITE  = ctrl_out_s.irwrite;
  assign bus.REGWRITE = ctrl_out_s.regwrite;
  assign bus.MEMTOREG = ctrl_out_s.memtoreg;
  assign bus.ALUSRCA  = ctrl_out_s.alusrca;
  assign bus.ALUSRCB  = ctrl_out_s.alusrcb;
  assign bus.ALUOP    = ctrl_out_s.aluop;
  assign bus.IMMSEL   = ctrl_out_s.immsel;
  assign bus.HALTED   = ctrl_out_s.halted;
  assign bus.ERR      = ctrl_out_s.err;
  assign bus.STATE    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// state sequence and checks controls, memory waits, timeout, reset and halt.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_vec = 0;
  int   n_err = 0;

  mc_control_fsm_if #(.OPW(4)) bus ();

  mc_control_fsm #(.OPW(4), .MEM_TIMEOUT(15)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // {MEM_REQ,MEM_WE,IORD,PCWRITE,PCSRC[1:0],IRWRITE,REGWRITE,MEMTOREG,ALUSRCA,
  //  ALUSRCB[1:0],ALUOP[2:0],IMMSEL[1:0],HALTED,ERR}
  logic [18:0] outs_s;
  assign outs_s = {bus.MEM_REQ, bus.MEM_WE, bus.IORD, bus.PCWRITE, bus.PCSRC,
                   bus.IRWRITE, bus.REGWRITE, bus.MEMTOREG, bus.ALUSRCA,
                   bus.ALUSRCB, bus.ALUOP, bus.IMMSEL, bus.HALTED, bus.ERR};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_outs", 32'(outs_s), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  initial begin
    RST_N         = 1'b0;
    bus.OPCODE    = 4'h0;
    bus.ZERO      = 1'b0;
    bus.MEM_READY = 1'b0;
    #2;
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_outs", 32'(outs_s), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // ADD with zero-wait memory: 0,1,2,7,0
    bus.MEM_READY = 1'b1;
    bus.OPCODE    = 4'h0;
    #1;
    chk("fetch_state", 32'(bus.STATE), 32'd0);
    chk("fetch_req", 32'(bus.MEM_REQ), 32'd1);
    chk("fetch_iord", 32'(bus.IORD), 32'd0);
    chk("fetch_srcb", 32'(bus.ALUSRCB), 32'd1);
    chk("fetch_irw", 32'(bus.IRWRITE), 32'd1);
    chk("fetch_pcw", 32'(bus.PCWRITE), 32'd1);
    chk("fetch_pcsrc", 32'(bus.PCSRC), 32'd0);
    tick();
    chk("add_dec_state", 32'(bus.STATE), 32'd1);
    chk("add_dec_irw", 32'(bus.IRWRITE), 32'd0);
    chk("add_dec_pcw", 32'(bus.PCWRITE), 32'd0);
    chk("add_dec_req", 32'(bus.MEM_REQ), 32'd0);
    chk("add_dec_srcb", 32'(bus.ALUSRCB), 32'd2);
    chk("add_dec_imm", 32'(bus.IMMSEL), 32'd2);
    tick();
    chk("add_ex_state", 32'(bus.STATE), 32'd2);
    chk("add_ex_srca", 32'(bus.ALUSRCA), 32'd1);
    chk("add_ex_srcb", 32'(bus.ALUSRCB), 32'd0);
    chk("add_ex_aluop", 32'(bus.ALUOP), 32'd0);
    tick();
    chk("add_wb_state", 32'(bus.STATE), 32'd7);
    chk("add_wb_regw", 32'(bus.REGWRITE), 32'd1);
    chk("add_wb_m2r", 32'(bus.MEMTOREG), 32'd0);
    tick();
    chk("add_end_state", 32'(bus.STATE), 32'd0);

    // SUB/AND/OR: ALUOP follows opcode in EXEC_R
    for (int k = 1; k < 4; k++) begin
      bus.OPCODE = 4'(k);
      tick();
      tick();
      chk("r_ex_state", 32'(bus.STATE), 32'd2);
      chk("r_ex_aluop", 32'(bus.ALUOP), 32'(k));
      tick();
      tick();
      chk("r_end_state", 32'(bus.STATE), 32'd0);
    end

    // ADDI then ORI
    bus.OPCODE = 4'h4;
    tick();
    chk("addi_dec_imm", 32'(bus.IMMSEL), 32'd2);
    chk("addi_dec_srcb", 32'(bus.ALUSRCB), 32'd2);
    tick();
    chk("addi_ex_state", 32'(bus.STATE), 32'd3);
    chk("addi_ex_imm", 32'(bus.IMMSEL), 32'd0);
    chk("addi_ex_aluop", 32'(bus.ALUOP), 32'd0);
    chk("addi_ex_srcb", 32'(bus.ALUSRCB), 32'd2);
    tick();
    tick();
    chk("addi_end_state", 32'(bus.STATE), 32'd0);
    bus.OPCODE = 4'h5;
    tick();
    chk("ori_dec_imm", 32'(bus.IMMSEL), 32'd2);
    chk("ori_dec_srcb", 32'(bus.ALUSRCB), 32'd2);
    tick();
    chk("ori_ex_imm", 32'(bus.IMMSEL), 32'd1);
    chk("ori_ex_aluop", 32'(bus.ALUOP), 32'd3);
    tick();
    chk("ori_wb_state", 32'(bus.STATE), 32'd7);
    tick();

    // LW with three wait cycles in MEM_RD: 8 cycles total
    bus.OPCODE = 4'h6;
    tick();
    tick();
    chk("lw_addr_state", 32'(bus.STATE), 32'd4);
    chk("lw_addr_imm", 32'(bus.IMMSEL), 32'd0);
    bus.MEM_READY = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_ctl", 32'({bus.STATE, bus.MEM_REQ, bus.IORD, bus.MEM_WE}), 32'({4'd5, 3'b110}));
      tick();
    end
    bus.MEM_READY = 1'b1;
    #1;
    chk("lw_done_ctl", 32'({bus.STATE, bus.MEM_REQ, bus.IORD, bus.MEM_WE}), 32'({4'd5, 3'b110}));
    tick();
    chk("lw_wb_state", 32'(bus.STATE), 32'd8);
    chk("lw_wb_m2r", 32'(bus.MEMTOREG), 32'd1);
    chk("lw_wb_regw", 32'(bus.REGWRITE), 32'd1);
    chk("lw_wb_req", 32'(bus.MEM_REQ), 32'd0);
    tick();
    chk("lw_end_state", 32'(bus.STATE), 32'd0);

    // SW: MEM_WR completes straight back into FETCH, request stays high
    bus.OPCODE = 4'h7;
    tick();
    tick();
    tick();
    chk("sw_wr_ctl", 32'({bus.STATE, bus.MEM_REQ, bus.IORD, bus.MEM_WE}), 32'({4'd6, 3'b111}));
    tick();
    chk("sw_fetch_ctl", 32'({bus.STATE, bus.MEM_REQ, bus.MEM_WE}), 32'({4'd0, 2'b10}));

    // BEQ taken, BNE with ZERO=1 not taken then ZERO=0 taken
    bus.OPCODE = 4'h8;
    bus.ZERO   = 1'b1;
    tick();
    tick();
    chk("beq_state", 32'(bus.STATE), 32'd9);
    chk("beq_pcw", 32'(bus.PCWRITE), 32'd1);
    chk("beq_pcsrc", 32'(bus.PCSRC), 32'd1);
    chk("beq_aluop", 32'(bus.ALUOP), 32'd1);
    tick();
    chk("beq_end_state", 32'(bus.STATE), 32'd0);
    bus.OPCODE = 4'h9;
    tick();
    tick();
    chk("bne_state", 32'(bus.STATE), 32'd9);
    chk("bne_z1_pcw", 32'(bus.PCWRITE), 32'd0);
    bus.ZERO = 1'b0;
    #1;
    chk("bne_z0_pcw", 32'(bus.PCWRITE), 32'd1);
    tick();
    chk("bne_end_state", 32'(bus.STATE), 32'd0);

    // J
    bus.OPCODE = 4'hA;
    tick();
    tick();
    chk("j_ctl", 32'({bus.STATE, bus.PCWRITE, bus.PCSRC}), 32'({4'd10, 1'b1, 2'd2}));
    tick();
    chk("j_end_state", 32'(bus.STATE), 32'd0);

    // Opcode C
    bus.OPCODE = 4'hC;
    tick();
    tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    chk("opc_state", 32'(bus.STATE), 32'd12);
    chk("opc_err", 32'({bus.ERR, bus.HALTED}), 32'({1'b1, 1'b1}));
`else
    chk("opc_state", 32'(bus.STATE), 32'd0);
    chk("opc_err", 32'({bus.ERR, bus.HALTED}), 32'({1'b0, 1'b0}));
`endif

    // FETCH timeout: 15 wait cycles then ERRSTOP
    do_reset();
    bus.MEM_READY = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait", 32'({bus.STATE, bus.MEM_REQ}), 32'({4'd0, 1'b1}));
      tick();
    end
    chk("to_state", 32'(bus.STATE), 32'd12);
    chk("to_outs", 32'(outs_s), 32'h3);
    bus.MEM_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_sticky", 32'({bus.STATE, bus.ERR, bus.HALTED}), 32'({4'd12, 2'b11}));
    end

    // Reset mid-wait: outputs drop at once, wait counter restarts
    do_reset();
    bus.MEM_READY = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    RST_N = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.STATE), 32'd0);
    chk("midrst_outs", 32'(outs_s), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    for (int i = 0; i < 14; i++) tick();
    chk("midrst_w15", 32'({bus.STATE, bus.MEM_REQ}), 32'({4'd0, 1'b1}));
    tick();
    chk("midrst_to", 32'(bus.STATE), 32'd12);

    // HALT holds for 20+ cycles regardless of MEM_READY
    do_reset();
    bus.MEM_READY = 1'b1;
    bus.OPCODE    = 4'hF;
    tick();
    tick();
    chk("halt_state", 32'(bus.STATE), 32'd11);
    chk("halt_outs", 32'(outs_s), 32'h2);
    for (int i = 0; i < 22; i++) begin
      bus.MEM_READY = i[0];
      tick();
      chk("halt_hold", 32'({bus.STATE, bus.HALTED, bus.ERR}), 32'({4'd11, 2'b10}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
